retime_pipe: RTL

- Parametrised, depth-configurable retiming pipeline for long valid/ready datapaths between GPU pipeline units (e.g. raster to shader dispatch, L1 to crossbar).
- Chains STAGES full-throughput two-entry skid stages.
- Both data and ready are registered at every stage boundary, so no combinational path runs from out_ready to in_ready.
- Sustains one transfer per cycle under arbitrary backpressure and supports a synchronous flush.

---
 rtl/retime_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/retime_pipe.sv
// retime_pipe: depth-configurable valid/ready retiming pipeline.
//
// Chains STAGES two-entry skid stages. Every stage boundary carries a registered valid,
// registered data and a registered ready, so out_ready never reaches in_ready through
// combinational logic. Full throughput (one word per cycle) under arbitrary backpressure.
//
// Parameters:
//   WIDTH   payload width in bits
//   STAGES  number of retiming stages (>= 1)
//   CNT_W   occupancy width, derived from STAGES
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   flush      synchronous drop of all buffered entries (rst has priority)
//   in_valid   upstream valid
//   in_ready   upstream ready (registered)
//   in_data    upstream payload
//   out_valid  downstream valid (registered)
//   out_ready  downstream ready
//   out_data   downstream payload (registered)
//   occupancy  number of words held, 0..2*STAGES
//   perf_stall_cnt  saturating count of out_valid && !out_ready cycles
//                   (only when RETIME_PIPE_PERF_EN is defined)
//
// Optional feature macro: RETIME_PIPE_PERF_EN

module retime_pipe #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned STAGES = 2,
    localparam int unsigned CNT_W = $clog2(2 * STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
`ifdef RETIME_PIPE_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    if (STAGES < 1) begin : g_bad_stages
        $error("retime_pipe: STAGES must be >= 1");
    end

    // State encoding is {mv, sv}: bit 1 is the stage output valid, bit 0 the skid valid.
    // Stage ready is simply ~state_q[0], a flop output.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b10,
        StFull  = 2'b11
    } stage_e;

    // Boundary s sits in front of stage s; boundary STAGES is the pipe output.
    logic [STAGES:0] link_valid;
    logic [STAGES:0] link_ready;
    logic [WIDTH-1:0] link_data [STAGES+1];

    assign link_valid[0]      = in_valid;
    assign link_data[0]       = in_data;
    assign link_ready[STAGES] = out_ready;

    assign in_ready  = link_ready[0];
    assign out_valid = link_valid[STAGES];
    assign out_data  = link_data[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        stage_e           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             acc;
        logic             tk;

        assign acc = link_valid[s] && !state_q[0];
        assign tk  = state_q[1] && link_ready[s+1];

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d = StBusy;
                        main_d  = link_data[s];
                    end
                end
                StBusy: begin
                    if (acc && tk) begin
                        main_d = link_data[s];
                    end else if (acc) begin
                        // Downstream stalled: park the new word, keep main presented.
                        state_d = StFull;
                        skid_d  = link_data[s];
                    end else if (tk) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (tk) begin
                        state_d = StBusy;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StEmpty;
                main_q  <= '0;
                skid_q  <= '0;
            end else if (flush) begin
                // Data registers keep their contents; only the valid bits drop.
                state_q <= StEmpty;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end

        assign link_valid[s+1] = state_q[1];
        assign link_data[s+1]  = main_q;
        assign link_ready[s]   = !state_q[0];
    end

    // Internal stage-to-stage moves do not change the total; only the pipe ends do.
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] occ_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else if (in_fire && !out_fire) begin
            occ_q <= occ_q + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_q <= occ_q - CNT_W'(1);
        end
    end

    assign occupancy = occ_q;

`ifdef RETIME_PIPE_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            perf_q <= '0;
        end else if (out_valid && !out_ready && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule
